// File: rtl/dmem_apb_interconnect.sv
// Data-side interconnect: routes CPU loads/stores either straight to RAM or
// through a single-outstanding APB master to one of NUM_SLAVES peripherals,
// stalling the pipeline until the APB transfer finishes or times out.
module dmem_apb_interconnect #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] PERIPH_HI  = 16'hFFFF,
  parameter int          SLOT_LSB   = 8,
  parameter int          TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_wen,
  input  logic                         cpu_ren,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         ram_we,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic [NUM_SLAVES-1:0]        apb_psel,
  output logic                         apb_penable,
  output logic [ADDR_W-1:0]            apb_paddr,
  output logic                         apb_pwrite,
  output logic [DATA_W-1:0]            apb_pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] apb_prdata,
  input  logic [NUM_SLAVES-1:0]        apb_pready,
  input  logic [NUM_SLAVES-1:0]        apb_pslverr,
  input  logic                         err_clear,
  output logic                         bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  localparam int              CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [4:0]       NSLV    = 5'(NUM_SLAVES);

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    bus_err_q, bus_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    periph_hit, ram_hit, req, slot_ok, set_err;
  logic [3:0]              slot;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    sel_ready, sel_err;
  logic [DATA_W-1:0]       sel_rdata;

  assign periph_hit = (cpu_addr[ADDR_W-1 -: 16] == PERIPH_HI);
  assign ram_hit    = (cpu_addr[ADDR_W-1 -: 16] == 16'h0000);
  assign req        = (cpu_wen | cpu_ren) & periph_hit;
  assign slot       = cpu_addr[SLOT_LSB+3:SLOT_LSB];
  assign slot_ok    = ({1'b0, slot} < NSLV);
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Pick the addressed slave's response using the one-hot PSEL as the selector.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_ready = apb_pready[i];
        sel_err   = apb_pslverr[i];
        sel_rdata = apb_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register with all APB, capture and error flops.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and sampled only on the clock edge.
    if (rst) begin
      state_q   <= S_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: decode, APB sequencing, timeout and error capture.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    set_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (slot_ok) begin
            paddr_d  = cpu_addr;
            pwdata_d = cpu_wdata;
            pwrite_d = cpu_wen;
            cnt_d    = '0;
            psel_d   = '0;
            for (int i = 0; i < NUM_SLAVES; i++) begin
              if (slot == 4'(i)) psel_d[i] = 1'b1;
            end
            state_d = S_SETUP;
          end else begin
            // Unmapped slot: answer immediately with an error, no bus cycle.
            rdata_d = '0;
            set_err = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          rdata_d   = sel_err ? '0 : sel_rdata;
          set_err   = sel_err;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_inc == CNT_MAX) begin
          rdata_d   = '0;
          set_err   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Set takes priority over a simultaneous clear.
    bus_err_d = set_err | (bus_err_q & ~err_clear);
  end

  // Output logic: pipeline stall, load-data mux and RAM write enable.
  always_comb begin
    cpu_stall = ((state_q == S_IDLE) && req) ||
                (state_q == S_SETUP) || (state_q == S_ACCESS);
    if (state_q == S_DONE) cpu_rdata = rdata_q;
    else if (ram_hit)      cpu_rdata = ram_rdata;
    else                   cpu_rdata = '0;
    ram_we = cpu_wen & ram_hit;
  end

  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_pwdata  = pwdata_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_dmem_apb_interconnect.sv
// Directed bench for dmem_apb_interconnect (NUM_SLAVES=4, TIMEOUT=255).
module tb_dmem_apb_interconnect;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_wen, cpu_ren;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_stall, ram_we;
  logic [DW-1:0]    ram_rdata;
  logic [NS-1:0]    apb_psel;
  logic             apb_penable;
  logic [AW-1:0]    apb_paddr;
  logic             apb_pwrite;
  logic [DW-1:0]    apb_pwdata;
  logic [NS*DW-1:0] apb_prdata;
  logic [NS-1:0]    apb_pready, apb_pslverr;
  logic             err_clear, bus_err;

  int checks = 0;
  int errors = 0;
  int stalls;
  logic done;

  dmem_apb_interconnect dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_paddr(apb_paddr),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .err_clear(err_clear), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    cpu_wen   = 1'b0;
    cpu_ren   = 1'b0;
    cpu_addr  = 32'h1000_0000;
    cpu_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_bus();
    ram_rdata   = '0;
    apb_prdata  = '0;
    apb_pready  = 4'hF;
    apb_pslverr = '0;
    err_clear   = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    smp();
    check("rst_psel",    apb_psel, 0);
    check("rst_penable", apb_penable, 0);
    check("rst_paddr",   apb_paddr, 0);
    check("rst_pwrite",  apb_pwrite, 0);
    check("rst_pwdata",  apb_pwdata, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall",   cpu_stall, 0);
    check("rst_rdata",   cpu_rdata, 0);

    // Write 0xA5 to slave1, zero-wait.
    cyc();
    cpu_addr = 32'hFFFF_0100; cpu_wdata = 32'hA5; cpu_wen = 1'b1;
    smp();
    check("w1_req_stall", cpu_stall, 1);
    check("w1_req_psel",  apb_psel, 0);
    cyc(); smp();
    check("w1_setup_psel",    apb_psel, 4'b0010);
    check("w1_setup_penable", apb_penable, 0);
    check("w1_setup_pwrite",  apb_pwrite, 1);
    check("w1_setup_pwdata",  apb_pwdata, 32'hA5);
    check("w1_setup_paddr",   apb_paddr, 32'hFFFF_0100);
    check("w1_setup_stall",   cpu_stall, 1);
    cyc(); smp();
    check("w1_access_psel",    apb_psel, 4'b0010);
    check("w1_access_penable", apb_penable, 1);
    check("w1_access_stall",   cpu_stall, 1);
    cyc(); smp();
    check("w1_done_psel",    apb_psel, 0);
    check("w1_done_penable", apb_penable, 0);
    check("w1_done_stall",   cpu_stall, 0);
    check("w1_done_bus_err", bus_err, 0);
    cyc(); idle_bus();

    // Read slave2 with three wait states.
    cpu_addr = 32'hFFFF_0200; cpu_ren = 1'b1;
    apb_pready = 4'b1011;
    apb_prdata[2*DW +: DW] = 32'h1234;
    stalls = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) apb_pready[2] = 1'b1;
      smp();
      if (cpu_stall) stalls++;
      if (c == 3) begin
        check("r2_pwrite",  apb_pwrite, 0);
        check("r2_penable", apb_penable, 1);
        check("r2_psel",    apb_psel, 4'b0100);
      end
      cyc();
    end
    smp();
    check("r2_stall_count", stalls, 6);
    check("r2_done_stall",  cpu_stall, 0);
    check("r2_done_rdata",  cpu_rdata, 32'h1234);
    check("r2_done_psel",   apb_psel, 0);
    cyc(); idle_bus();

    // Slave0 never ready: timeout abort.
    cpu_addr = 32'hFFFF_0000; cpu_ren = 1'b1;
    apb_pready = 4'b1110;
    apb_prdata[0 +: DW] = 32'hDEAD;
    stalls = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      smp();
      if (c == 10) check("to_psel_mid", apb_psel, 4'b0001);
      if (cpu_stall) begin
        stalls++;
        cyc();
      end else begin
        done = 1'b1;
      end
    end
    check("to_reached_done", done, 1);
    check("to_stall_count",  stalls, 257);
    check("to_psel",    apb_psel, 0);
    check("to_penable", apb_penable, 0);
    check("to_rdata",   cpu_rdata, 0);
    check("to_bus_err", bus_err, 1);
    cyc(); idle_bus(); apb_pready = 4'hF;

    // RAM store then load; bus_err stays sticky.
    cpu_addr = 32'h0000_0040; cpu_wen = 1'b1; cpu_wdata = 32'h77;
    smp();
    check("ram_st_we",    ram_we, 1);
    check("ram_st_stall", cpu_stall, 0);
    check("ram_st_psel",  apb_psel, 0);
    cyc();
    cpu_wen = 1'b0; cpu_ren = 1'b1; ram_rdata = 32'hCAFE;
    smp();
    check("ram_ld_we",      ram_we, 0);
    check("ram_ld_rdata",   cpu_rdata, 32'hCAFE);
    check("ram_ld_stall",   cpu_stall, 0);
    check("ram_ld_psel",    apb_psel, 0);
    check("ram_ld_penable", apb_penable, 0);
    check("ram_ld_bus_err", bus_err, 1);
    cyc();
    cpu_addr = 32'h1000_0040; cpu_wen = 1'b1; cpu_ren = 1'b0;
    smp();
    check("out_we",    ram_we, 0);
    check("out_stall", cpu_stall, 0);
    check("out_rdata", cpu_rdata, 0);
    cyc(); idle_bus();

    // Reset during ACCESS to slave3.
    cpu_addr = 32'hFFFF_0300; cpu_wen = 1'b1; cpu_wdata = 32'h3;
    apb_pready = 4'b0111;
    cyc(); smp();
    check("rs_setup_psel", apb_psel, 4'b1000);
    cyc(); smp();
    check("rs_access_penable", apb_penable, 1);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; idle_bus(); apb_pready = 4'hF;
    smp();
    check("rs_psel",    apb_psel, 0);
    check("rs_penable", apb_penable, 0);
    check("rs_bus_err", bus_err, 0);
    check("rs_stall",   cpu_stall, 0);
    cyc(); smp();
    check("rs_no_resume", apb_psel, 0);

    // PSLVERR read from slave1 with err_clear held (set wins).
    cyc();
    cpu_addr = 32'hFFFF_0100; cpu_ren = 1'b1; err_clear = 1'b1;
    apb_pslverr = 4'b0010;
    apb_prdata[1*DW +: DW] = 32'h5555;
    cyc(); cyc(); cyc(); smp();
    check("se_done_stall",   cpu_stall, 0);
    check("se_done_rdata",   cpu_rdata, 0);
    check("se_done_bus_err", bus_err, 1);
    cyc(); idle_bus(); smp();
    check("se_cleared", bus_err, 0);
    cyc(); err_clear = 1'b0; apb_pslverr = '0;

    // Unmapped slot 5.
    cpu_addr = 32'hFFFF_0500; cpu_ren = 1'b1;
    smp();
    check("um_req_stall", cpu_stall, 1);
    check("um_req_psel",  apb_psel, 0);
    cyc(); smp();
    check("um_done_stall",   cpu_stall, 0);
    check("um_done_rdata",   cpu_rdata, 0);
    check("um_done_bus_err", bus_err, 1);
    check("um_done_psel",    apb_psel, 0);
    cyc(); idle_bus(); err_clear = 1'b1; smp();
    check("um_clr_pending", bus_err, 1);
    cyc(); err_clear = 1'b0; smp();
    check("um_cleared", bus_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
